wb_trace_uart: RTL and testbench
================================

# wb_trace_uart

Debug trace stage downstream of the RV32I processor core: it watches the core's 32-bit writeback data bus, captures every change into a small FIFO, and streams each captured word out of a UART TX pin as 8 uppercase hex characters plus CR LF. It sits beside the processor in the board-level top so retired writeback values can be read on a terminal, with no VIO or ILA. It never back-pressures the core; a word that arrives while the FIFO is full is dropped and counted.

## Interface

Parameters:
- CLK_FREQ_HZ, 100_000_000, clock frequency; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (integer division, must be ≥ 2).
- BAUD, 115200, serial bit rate.
- FIFO_DEPTH, 16, capture FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; every register below is sampled into its reset value on a clk rising edge with reset = 1.
- wb_data  in  32  processor writeback data, sampled every clk edge.
- uart_tx  out  1  serial output, 8N1, idle high.
- busy  out  1  high while a frame is being shifted out.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- drop_count  out  8  count of dropped captures, saturating at 255.

## Operation

- Change detect: register prev_wb (reset 0) loads wb_data every edge. A capture is requested on any edge where wb_data != prev_wb. A nonzero value present right after reset is therefore captured.
- Push: a capture is written when fifo_full = 0 at that edge. This includes an edge with a simultaneous pop. If fifo_full = 1, the word is dropped, even if a pop occurs the same edge, and drop_count increments unless it is already 255.
- Pop: on an edge where the TX FSM is IDLE and the FIFO is non-empty, the head word is loaded into the frame register and the FIFO count decrements.
- Frame: chars 0–7 are the hex nibbles, MSB nibble first, encoded as '0'–'9' and 'A'–'F'. Char 8 is 0x0D and char 9 is 0x0A.
- TX FSM states:
  - IDLE: go to START on a pop; char index is set to 0.
  - START: uart_tx = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: uart_tx = 1 for CLKS_PER_BIT cycles. Then go to START with index+1 if index < 9; otherwise go to IDLE.
- busy = 1 in START, DATA and STOP.
- Reset values: uart_tx = 1, busy = 0, fifo_full = 0, drop_count = 0. The FIFO is emptied, the FSM is IDLE, the bit and baud counters are 0, and prev_wb = 0.

## Timing

- Capture-to-line latency: a change is sampled at edge k and pushed at edge k. If TX is IDLE and the FIFO was empty, the word is popped at edge k+1 and uart_tx goes low from edge k+2.
- Frame length is 10 chars × 10 bits × CLKS_PER_BIT cycles. Back-to-back frames: the pop happens on the first IDLE edge after STOP of char 9, giving one IDLE cycle between frames.
- Reset mid-frame: uart_tx = 1 from the reset edge. The partial frame is abandoned and never resumed, and FIFO contents are lost.
- fifo_full and drop_count update on the edge of the push, pop or drop that changes them.

## Configuration

- WB_TRACE_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter is added. It resets to 0, increments every non-reset edge and wraps at 0xFFFF.
  - The counter value before the push edge's increment is stored with each word, so the FIFO entry width is 48.
  - The frame becomes 15 chars: 4 hex timestamp chars (MSB first), 0x20, 8 data hex chars, 0x0D, 0x0A.
- Undefined: no counter is built, the FIFO entry width is 32, and the frame is 10 chars as above.

## Test plan

Use CLK_FREQ_HZ = 1_000_000, BAUD = 100_000 (CLKS_PER_BIT = 10), FIFO_DEPTH = 16. The bench has a UART decoder on uart_tx.
- Reset, then hold wb_data = 0 for 5000 cycles → uart_tx = 1, busy = 0, fifo_full = 0, drop_count = 0 throughout.
- Change wb_data 0 → 0xDEADBEEF at edge k → uart_tx low from edge k+2; decoder receives "DEADBEEF",0x0D,0x0A; busy high for exactly 1000 cycles.
- Drive 0x1, 0x2, 0x1 on three consecutive edges, then hold → three frames, in order "00000001", "00000002", "00000001"; drop_count = 0.
- Drive 20 distinct nonzero values on consecutive edges → 1st popped immediately, 2nd–17th stored, fifo_full = 1, drop_count = 3; 17 frames decoded in order. Then drive 300 further changes while full → drop_count saturates at 255.
- Assert reset during the data bits of char 3 of a frame with 5 words queued → uart_tx = 1 from the reset edge; after release with wb_data = 0, no further characters appear.
- With WB_TRACE_TIMESTAMP_EN defined, change wb_data to 0x5 on the 100th edge after reset release → decoder receives "0063 00000005",0x0D,0x0A.

Source files
------------

// File: rtl/wb_trace_uart.sv
// wb_trace_uart: watches the 32-bit writeback bus, queues every change in a
// small FIFO and prints each queued word on a UART TX line as uppercase hex
// followed by CR LF (8N1, idle high).
//
// Optional feature macro: WB_TRACE_TIMESTAMP_EN. When defined, a 16-bit
// free-running cycle stamp is stored with each word and printed as
// "TTTT " in front of the data characters.
//
// Flow control: the writeback side has no ready signal and is never stalled.
// A change is pushed on the edge it is seen if the FIFO is not full, and is
// dropped (and counted) otherwise. The TX FSM pops the head word only on an
// edge where it is IDLE and the FIFO is non-empty. Push and pop may share an
// edge; a full FIFO still drops on an edge that also pops.
module wb_trace_uart #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W      = 48;
  localparam int NUM_CHARS    = 15;
`else
  localparam int ENTRY_W      = 32;
  localparam int NUM_CHARS    = 10;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // TX FSM state is kept in a plainly named register so checkers can bind to it.
  tx_state_t          state, state_d;
  logic [BAUD_W-1:0]  baud_cnt, baud_d;
  logic [2:0]         bit_idx, bit_d;
  logic [3:0]         char_idx, char_d;

  logic [31:0]        prev_wb;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] frame_q;
  logic [ENTRY_W-1:0] push_word;
  logic               tx_q;

  logic               change, push, pop, drop;
  logic               baud_done;
  logic [5:0]         nib_shift;
  logic [3:0]         nib;
  logic               fixed_sel;
  logic [7:0]         fixed_char;
  logic [7:0]         cur_char;
  logic               line_bit;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign change    = (wb_data != prev_wb);
  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push      = change && !fifo_full;
  assign drop      = change && fifo_full;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);
  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy      = (state != S_IDLE);
  assign uart_tx   = tx_q;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [15:0] ts_count;

  // Free-running cycle stamp; the pre-increment value goes into the FIFO.
  always_ff @(posedge clk) begin
    if (reset) ts_count <= 16'h0000;
    else       ts_count <= ts_count + 16'h0001;
  end

  assign push_word = {ts_count, wb_data};
`else
  assign push_word = wb_data;
`endif

  // Previous writeback value for change detection.
  always_ff @(posedge clk) begin
    if (reset) prev_wb <= 32'h0;
    else       prev_wb <= wb_data;
  end

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Saturating count of captures lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset)                            drop_count <= 8'h00;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
  end

  // Frame register holds the word being printed.
  always_ff @(posedge clk) begin
    if (reset)    frame_q <= '0;
    else if (pop) frame_q <= fifo_mem[rd_ptr];
  end

  // TX FSM state, baud, bit and character counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      char_idx <= char_d;
    end
  end

  // Next-state logic: START, 8 DATA bits, STOP per character, then the next
  // character or back to IDLE after the LF.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    char_d  = char_idx;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          char_d  = '0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_d   = bit_idx + 3'd1;
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (char_idx == 4'(NUM_CHARS - 1)) begin
            state_d = S_IDLE;
            char_d  = '0;
          end else begin
            state_d = S_START;
            char_d  = char_idx + 4'd1;
          end
        end else begin
          baud_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Character selection: hex nibbles MSB first, optional space, then CR LF.
  always_comb begin
    nib_shift  = 6'd0;
    fixed_sel  = 1'b0;
    fixed_char = 8'h00;
`ifdef WB_TRACE_TIMESTAMP_EN
    if (char_idx < 4'd4) begin
      nib_shift = 6'd44 - {char_idx, 2'b00};
    end else if (char_idx == 4'd4) begin
      fixed_sel  = 1'b1;
      fixed_char = 8'h20;
    end else if (char_idx < 4'd13) begin
      nib_shift = 6'd48 - {char_idx, 2'b00};
    end else if (char_idx == 4'd13) begin
      fixed_sel  = 1'b1;
      fixed_char = 8'h0D;
    end else begin
      fixed_sel  = 1'b1;
      fixed_char = 8'h0A;
    end
`else
    if (char_idx < 4'd8) begin
      nib_shift = 6'd28 - {char_idx, 2'b00};
    end else if (char_idx == 4'd8) begin
      fixed_sel  = 1'b1;
      fixed_char = 8'h0D;
    end else begin
      fixed_sel  = 1'b1;
      fixed_char = 8'h0A;
    end
`endif
    nib      = 4'(frame_q >> nib_shift);
    cur_char = fixed_sel ? fixed_char : hex_char(nib);
  end

  // Line level implied by the current state.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START: line_bit = 1'b0;
      S_DATA:  line_bit = cur_char[bit_idx];
      default: line_bit = 1'b1;
    endcase
  end

  // Registered TX pin: glitch-free, goes high on the reset edge.
  always_ff @(posedge clk) begin
    if (reset) tx_q <= 1'b1;
    else       tx_q <= line_bit;
  end

endmodule

// File: tb/tb_wb_trace_uart.sv
// Bench for wb_trace_uart: UART decoder on uart_tx, a queue-based reference
// model of capture/drop/print behaviour, directed corner sequences, a vector
// table of hex encodings and a randomized phase.
module tb_wb_trace_uart;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;
  localparam int DEPTH       = 16;
`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int NCHARS      = 15;
`else
  localparam int NCHARS      = 10;
`endif
  localparam int FRAME_CYCLES = NCHARS * 10 * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_data;
  logic        uart_tx;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  wb_trace_uart #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_data    (wb_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .drop_count (drop_count)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words waiting in the FIFO, remaining cycles of the frame in flight, and
  // the bytes the decoder should see next.
  logic [47:0] m_q[$];
  int          m_busy_left;
  int          m_drops;
  logic [31:0] m_prev;
  logic [15:0] m_ts;
  logic [7:0]  exp_q[$];
  bit          m_chg, m_pop, m_push;

  function automatic void push_frame(input logic [47:0] e);
    string s;
`ifdef WB_TRACE_TIMESTAMP_EN
    s = $sformatf("%04x %08x", e[47:32], e[31:0]);
`else
    s = $sformatf("%08x", e[31:0]);
`endif
    s = s.toupper();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_busy_left = 0;
      m_drops     = 0;
      m_prev      = 32'h0;
      m_ts        = 16'h0;
    end else begin
      m_chg  = (wb_data != m_prev);
      m_pop  = (m_busy_left == 0) && (m_q.size() != 0);
      m_push = m_chg && (m_q.size() != DEPTH);
      if (m_busy_left > 0) m_busy_left--;
      if (m_pop) begin
        push_frame(m_q.pop_front());
        m_busy_left = FRAME_CYCLES;
      end
      if (m_push)                    m_q.push_back({m_ts, wb_data});
      else if (m_chg && m_drops < 255) m_drops++;
      m_prev = wb_data;
      m_ts   = m_ts + 16'h1;
    end
  end

  // Per-cycle status comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, (m_busy_left != 0));
      check("fifo_full", fifo_full, (m_q.size() == DEPTH));
      check("drop_count", drop_count, m_drops);
    end
  end

  // ---------------- UART decoder + byte scoreboard ----------------
  bit          rx_active = 1'b0;
  int          rx_timer, rx_pos;
  int          rx_bytes  = 0;
  logic [7:0]  rx_shift;
  logic [7:0]  cur_line[$];
  logic [7:0]  last_line[$];
  logic [63:0] line_data_q[$];
  int          line_len_q[$];

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_active = 1'b0;
      cur_line.delete();
    end else if (chk_on && !rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_timer  = CPB / 2;
        rx_pos    = 0;
      end
    end else if (rx_active) begin
      rx_timer--;
      if (rx_timer == 0) begin
        rx_timer = CPB;
        if (rx_pos == 0) begin
          check("start_bit", uart_tx, 1'b0);
        end else if (rx_pos <= 8) begin
          rx_shift[rx_pos-1] = uart_tx;
        end else begin
          logic [63:0] d;
          int len;
          rx_active = 1'b0;
          rx_bytes++;
          check("stop_bit", uart_tx, 1'b1);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected got=%0h exp=none t=%0t", rx_shift, $time);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx_shift !== e) begin
              failures++;
              $display("FAIL rx_char got=%0h exp=%0h t=%0t", rx_shift, e, $time);
            end
          end
          cur_line.push_back(rx_shift);
          if (rx_shift == 8'h0A) begin
            len = cur_line.size();
            d = '0;
            if (len >= 10)
              for (int i = 0; i < 8; i++) d[63-8*i -: 8] = cur_line[len-10+i];
            line_data_q.push_back(d);
            line_len_q.push_back(len);
            last_line = cur_line;
            cur_line.delete();
          end
        end
        rx_pos++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers leave the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] v);
    wb_data = v;
    tick();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (!(m_busy_left == 0 && m_q.size() == 0 && exp_q.size() == 0 && !rx_active)
           && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_idle_in_time", (n < max_cycles), 1'b1);
    repeat (3) tick();
  endtask

  task automatic wait_lines(input int count, input int max_cycles);
    int n;
    n = 0;
    while (line_data_q.size() < count && n < max_cycles) begin
      tick();
      n++;
    end
    check("lines_in_time", (n < max_cycles), 1'b1);
  endtask

  task automatic clear_lines();
    line_data_q.delete();
    line_len_q.delete();
  endtask

  task automatic check_line(input string name, input logic [63:0] exp_hex);
    logic [63:0] d;
    int len;
    d   = '0;
    len = 0;
    if (line_data_q.size() != 0) begin
      d   = line_data_q.pop_front();
      len = line_len_q.pop_front();
    end
    check(name, d, exp_hex);
    check({name, "_len"}, len, NCHARS);
  endtask

  function automatic logic [63:0] hex8(input logic [31:0] v);
    string s;
    logic [63:0] r;
    s = $sformatf("%08x", v);
    s = s.toupper();
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = s[i];
    return r;
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [63:0] hex;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int busy_n, bad, rx0, n;
    logic [31:0] v;
    string exp_s;

    vecs[0] = '{32'h0123_4567, "01234567"};
    vecs[1] = '{32'h89AB_CDEF, "89ABCDEF"};
    vecs[2] = '{32'hFFFF_FFFF, "FFFFFFFF"};
    vecs[3] = '{32'h0000_0000, "00000000"};
    vecs[4] = '{32'hA5A5_0F0F, "A5A50F0F"};

    // Reset and idle hold.
    reset   = 1'b1;
    wb_data = 32'h0;
    tick();
    chk_on = 1'b1;
    tick();
    @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_drop_count", drop_count, 8'd0);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0 || drop_count !== 8'd0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);
    tick();

    // Single word: latency, busy length, content.
    clear_lines();
    drive_word(32'hDEAD_BEEF);
    @(negedge clk);
    check("lat_k_tx", uart_tx, 1'b1);
    @(negedge clk);
    check("lat_k1_tx", uart_tx, 1'b1);
    check("lat_k1_busy", busy, 1'b1);
    busy_n = 0;
    for (int i = 0; i < 3 * FRAME_CYCLES; i++) begin
      if (busy !== 1'b1) break;
      busy_n++;
      @(negedge clk);
      if (i == 0) check("lat_k2_tx", uart_tx, 1'b0);
    end
    check("busy_cycles", busy_n, FRAME_CYCLES);
    tick();
    wait_lines(1, 200);
    check_line("line_deadbeef", "DEADBEEF");
    wait_idle(FRAME_CYCLES);

    // Three consecutive edges, repeated value included.
    clear_lines();
    drive_word(32'h1);
    drive_word(32'h2);
    drive_word(32'h1);
    wait_lines(3, 4 * (FRAME_CYCLES + 1));
    check_line("seq_1", "00000001");
    check_line("seq_2", "00000002");
    check_line("seq_3", "00000001");
    check("seq_drops", drop_count, 8'd0);
    wait_idle(FRAME_CYCLES);

    // Vector table of hex encodings.
    for (int i = 0; i < 5; i++) begin
      clear_lines();
      drive_word(vecs[i].word);
      wait_lines(1, 2 * FRAME_CYCLES);
      check_line($sformatf("vec_%0d", i), vecs[i].hex);
      wait_idle(FRAME_CYCLES);
    end

    // Overflow: 20 back-to-back words, then saturation of the drop counter.
    clear_lines();
    for (int i = 0; i < 20; i++) drive_word(32'h100 + i);
    @(negedge clk);
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_drops3", drop_count, 8'd3);
    tick();
    for (int i = 0; i < 300; i++) drive_word(32'h1000 + i);
    @(negedge clk);
    check("ovf_full_still", fifo_full, 1'b1);
    check("ovf_drops_sat", drop_count, 8'd255);
    tick();
    wait_lines(17, 18 * (FRAME_CYCLES + 1) + 500);
    for (int i = 0; i < 17; i++) check_line($sformatf("ovf_line_%0d", i), hex8(32'h100 + i));
    wait_idle(FRAME_CYCLES);

    // Reset during the data bits of char 3 with 5 words queued.
    clear_lines();
    for (int i = 0; i < 6; i++) drive_word(32'h200 + i);
    n = 0;
    while (cur_line.size() < 3 && n < 2 * FRAME_CYCLES) begin
      @(negedge clk);
      n++;
    end
    check("midrst_char3_reached", (cur_line.size() == 3), 1'b1);
    repeat (30) @(negedge clk);
    tick();
    reset   = 1'b1;
    wb_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", uart_tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fifo_full", fifo_full, 1'b0);
    check("midrst_drop_count", drop_count, 8'd0);
    tick();
    reset = 1'b0;
    rx0 = rx_bytes;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    check("midrst_line_quiet", bad, 0);
    check("midrst_no_chars", rx_bytes - rx0, 0);
    tick();

    // Randomized bursts and gaps against the model.
    for (int b = 0; b < 5; b++) begin
      int blen;
      blen = $urandom_range(1, 6);
      for (int i = 0; i < blen; i++) begin
        v = $urandom;
        drive_word(v);
      end
      repeat ($urandom_range(0, 1500)) tick();
    end
    wait_idle(40 * (FRAME_CYCLES + 1));

`ifdef WB_TRACE_TIMESTAMP_EN
    // Timestamp: change on the 100th edge after reset release.
    clear_lines();
    reset   = 1'b1;
    wb_data = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    repeat (99) tick();
    drive_word(32'h5);
    wait_lines(1, 2 * FRAME_CYCLES);
    exp_s = "0063 00000005";
    check("ts_len", last_line.size(), 15);
    if (last_line.size() == 15) begin
      for (int i = 0; i < 13; i++) check($sformatf("ts_char_%0d", i), last_line[i], exp_s[i]);
      check("ts_cr", last_line[13], 8'h0D);
      check("ts_lf", last_line[14], 8'h0A);
    end
    wait_idle(FRAME_CYCLES);
`else
    exp_s = "";
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop in case a bounded wait is ever bypassed.
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
